// File: rtl/joystick_spi_responder.sv
// SPI mode-0 slave emulating the joystick end of the joystick SPI exchange.
// Serves host-supplied X/Y/button values and captures the master's LED command byte.
module joystick_spi_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter int          NUM_BYTES   = 5,
    parameter logic [5:0]  CMD_PREFIX  = 6'b100000
) (
    input  logic       spi_clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs,
    input  logic       mosi,
    output logic       miso,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    input  logic [2:0] btn,
    output logic [1:0] led,
    output logic       frame_done,
    output logic       frame_err
);

    localparam int FB = 8 * NUM_BYTES;
    localparam int CW = $clog2(FB + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(FB);
    localparam logic [CW-1:0] CNT_OVER = CW'(FB + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
    logic                   sck_h, cs_h;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, cs_fall, cs_rise;

    logic [FB-1:0] tx, tx_nxt, tx_load;
    logic [FB-1:0] rx, rx_nxt;
    logic [CW-1:0] bit_cnt, cnt_nxt;
    logic          miso_nxt;
    logic [1:0]    led_nxt;
    logic          done_nxt, err_nxt;

    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            sck_sync  <= '1;
            cs_sync   <= '1;
            mosi_sync <= '0;
            sck_h     <= 1'b1;
            cs_h      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            sck_h     <= sck_sync[SYNC_STAGES-1];
            cs_h      <= cs_sync[SYNC_STAGES-1];
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_h;
    assign sck_fall = ~sck_s & sck_h;
    assign cs_fall  = ~cs_s & cs_h;
    assign cs_rise  = cs_s & ~cs_h;

    // Payload occupies the first five bytes; any further bytes shift out as zero.
    always_comb begin
        tx_load = '0;
        tx_load[FB-1 -: 40] = {x_pos[7:0], 6'b0, x_pos[9:8],
                               y_pos[7:0], 6'b0, y_pos[9:8],
                               5'b0, btn};
    end

    always_comb begin
        state_nxt = state;
        tx_nxt    = tx;
        rx_nxt    = rx;
        cnt_nxt   = bit_cnt;
        miso_nxt  = miso;
        led_nxt   = led;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall) begin
                    state_nxt = SHIFT;
                    tx_nxt    = tx_load;
                    miso_nxt  = tx_load[FB-1];
                    rx_nxt    = '0;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                // cs release takes priority over any sck edge seen in the same cycle
                if (cs_rise) begin
                    state_nxt = IDLE;
                    miso_nxt  = 1'b0;
                    if (bit_cnt == CNT_FULL && rx[FB-1 -: 6] == CMD_PREFIX) begin
                        led_nxt  = rx[FB-7 -: 2];
                        done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end else begin
                    if (sck_rise) begin
                        rx_nxt = {rx[FB-2:0], mosi_s};
                        if (bit_cnt != CNT_OVER)
                            cnt_nxt = bit_cnt + CW'(1);
                    end
                    if (sck_fall) begin
                        tx_nxt   = {tx[FB-2:0], 1'b0};
                        miso_nxt = tx[FB-2];
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge spi_clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tx         <= '0;
            rx         <= '0;
            bit_cnt    <= '0;
            miso       <= 1'b0;
            led        <= 2'b00;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_nxt;
            tx         <= tx_nxt;
            rx         <= rx_nxt;
            bit_cnt    <= cnt_nxt;
            miso       <= miso_nxt;
            led        <= led_nxt;
            frame_done <= done_nxt;
            frame_err  <= err_nxt;
        end
    end

endmodule

// File: tb/tb_joystick_spi_responder.sv
// Directed bench for joystick_spi_responder: a behavioural SPI master drives
// frames at sck = spi_clk/16 and compares against hand-computed values.
module tb_joystick_spi_responder;

    logic       spi_clk;
    logic       reset;
    logic       sck;
    logic       cs;
    logic       mosi;
    logic       miso;
    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic [2:0] btn;
    logic [1:0] led;
    logic       frame_done;
    logic       frame_err;

    int compared   = 0;
    int mismatched = 0;
    int done_cnt   = 0;
    int err_cnt    = 0;
    int both_cnt   = 0;
    int done_base, err_base;
    logic [47:0] cap;

    joystick_spi_responder #(
        .SYNC_STAGES(2),
        .NUM_BYTES  (5),
        .CMD_PREFIX (6'b100000)
    ) dut (
        .spi_clk   (spi_clk),
        .reset     (reset),
        .sck       (sck),
        .cs        (cs),
        .mosi      (mosi),
        .miso      (miso),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .btn       (btn),
        .led       (led),
        .frame_done(frame_done),
        .frame_err (frame_err)
    );

    initial spi_clk = 1'b0;
    always #5 spi_clk = ~spi_clk;

    always @(posedge spi_clk) begin
        if (frame_done) done_cnt <= done_cnt + 1;
        if (frame_err) err_cnt <= err_cnt + 1;
        if (frame_done && frame_err) both_cnt <= both_cnt + 1;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, observed hang, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends nbits of mosi_bits (MSB-aligned at bit 47), capturing miso just before each sck rise.
    task automatic spi_frame(input logic [47:0] mosi_bits, input int nbits,
                             input int change_bit, input int reset_bit,
                             output logic [47:0] rcv);
        rcv = '0;
        cs  = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            if (i == change_bit) x_pos = 10'h3FF;
            if (i == reset_bit) begin
                reset = 1'b1;
                #1;
                check("reset_mid_led", {46'd0, led}, 48'd0);
                check("reset_mid_miso", {47'd0, miso}, 48'd0);
                cs   = 1'b1;
                sck  = 1'b0;
                mosi = 1'b0;
                #49;
                reset = 1'b0;
                #100;
                return;
            end
            mosi = mosi_bits[47-i];
            #80;
            rcv = {rcv[46:0], miso};
            sck = 1'b1;
            #80;
            sck = 1'b0;
        end
        #80;
        cs   = 1'b1;
        mosi = 1'b0;
    endtask

    task automatic mark();
        done_base = done_cnt;
        err_base  = err_cnt;
    endtask

    task automatic settle_and_count(input string tag, input int exp_done, input int exp_err,
                                    input logic [1:0] exp_led);
        #100;
        check({tag, "_done"}, 48'(done_cnt - done_base), 48'(exp_done));
        check({tag, "_err"}, 48'(err_cnt - err_base), 48'(exp_err));
        check({tag, "_led"}, {46'd0, led}, {46'd0, exp_led});
    endtask

    initial begin
        reset = 1'b1;
        sck   = 1'b0;
        cs    = 1'b1;
        mosi  = 1'b0;
        x_pos = 10'h2A5;
        y_pos = 10'h13C;
        btn   = 3'b101;
        #3;
        #20;
        check("rst_miso", {47'd0, miso}, 48'd0);
        check("rst_led", {46'd0, led}, 48'd0);
        check("rst_done", {47'd0, frame_done}, 48'd0);
        check("rst_err", {47'd0, frame_err}, 48'd0);
        reset = 1'b0;
        #100;

        // Nominal frame, command 0x83
        mark();
        spi_frame(48'h830000000000, 40, -1, -1, cap);
        check("nom_miso", {8'd0, cap[39:0]}, 48'h00A5023C0105);
        #5;
        check("nom_led_latency", {46'd0, led}, 48'd0);
        #30;
        check("nom_miso_idle", {47'd0, miso}, 48'd0);
        settle_and_count("nom", 1, 0, 2'b11);

        // Bad prefix, command 0x43
        mark();
        spi_frame(48'h430000000000, 40, -1, -1, cap);
        check("badpfx_miso", {8'd0, cap[39:0]}, 48'h00A5023C0105);
        settle_and_count("badpfx", 0, 1, 2'b11);

        // Abort after 17 bits
        mark();
        spi_frame(48'h830000000000, 17, -1, -1, cap);
        check("abort_miso_bits", cap, 48'h14A04);
        #35;
        check("abort_miso_low", {47'd0, miso}, 48'd0);
        settle_and_count("abort", 0, 1, 2'b11);

        // Overlong: 48 bits, command 0x82
        mark();
        spi_frame(48'h820000000000, 48, -1, -1, cap);
        check("over_payload", {8'd0, cap[47:8]}, 48'h00A5023C0105);
        check("over_tail", {40'd0, cap[7:0]}, 48'd0);
        settle_and_count("over", 0, 1, 2'b11);

        // Snapshot: x_pos changes after byte 0
        x_pos = 10'h000;
        #50;
        mark();
        spi_frame(48'h830000000000, 40, 8, -1, cap);
        check("snap_frame1", {8'd0, cap[39:0]}, 48'h0000003C0105);
        settle_and_count("snap1", 1, 0, 2'b11);
        mark();
        spi_frame(48'h830000000000, 40, -1, -1, cap);
        check("snap_frame2", {8'd0, cap[39:0]}, 48'h00FF033C0105);
        settle_and_count("snap2", 1, 0, 2'b11);

        // Reset at bit 20, then a full 0x81 frame
        spi_frame(48'h830000000000, 40, -1, 20, cap);
        mark();
        spi_frame(48'h810000000000, 40, -1, -1, cap);
        check("post_rst_miso", {8'd0, cap[39:0]}, 48'h00FF033C0105);
        settle_and_count("post_rst", 1, 0, 2'b01);

        check("never_both", 48'(both_cnt), 48'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
